// File: rtl/decoder_arbiter_pkg.sv
// Shared definitions for the round-robin decoder arbiter: widths, state
// encoding, the default hold limit and the round-robin pick helper.
package decoder_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    localparam int unsigned DEFAULT_MAX_HOLD = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Scan startPtr, startPtr+1, ... (wrapping) and return the first
    // requester whose bit is set. Callers only use the result when at
    // least one bit is set, so the no-request fallback is arbitrary.
    function automatic logic [ID_W-1:0] rrPick(
        input logic [NUM_REQ-1:0] reqVec,
        input logic [ID_W-1:0]    startPtr
    );
        logic [ID_W-1:0] idx;
        logic            found;
        rrPick = startPtr;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = startPtr + ID_W'(i);
            if (!found && reqVec[idx]) begin
                rrPick = idx;
                found  = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/decoder_arbiter_decoder.sv
// The team's 2-to-4 decoder: drives exactly one output high when enabled,
// selected by the two address bits; all outputs low when disabled.
module structuralDecoder (
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3,
    input  logic addr0,
    input  logic addr1,
    input  logic enable
);

    assign out0 = enable & ~addr1 & ~addr0;
    assign out1 = enable & ~addr1 &  addr0;
    assign out2 = enable &  addr1 & ~addr0;
    assign out3 = enable &  addr1 &  addr0;

endmodule

// File: rtl/decoder_arbiter.sv
// Four-way round-robin arbiter. The owner ID and valid bit are registered
// and decoded into a one-hot grant, so gnt never follows req combinationally.
// An owner is preempted after MAX_HOLD cycles only if someone else is waiting.
module decoder_arbiter
    import decoder_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gntId,
    output logic               gntValid
);

    arb_state_t      state;
    logic [ID_W-1:0] ptr;
    logic [7:0]      holdCnt;

    logic [ID_W-1:0] nextPtr;
    logic            otherReq;
    logic            atMax;

    assign nextPtr  = gntId + ID_W'(1);
    assign otherReq = |(req & ~(NUM_REQ'(1) << gntId));
    assign atMax    = (holdCnt == 8'(MAX_HOLD));

    // Arbitration FSM: grant from idle, then release/preempt/saturate/hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            gntId    <= '0;
            gntValid <= 1'b0;
            ptr      <= '0;
            holdCnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != '0) begin
                        gntId    <= rrPick(req, ptr);
                        gntValid <= 1'b1;
                        holdCnt  <= 8'd1;
                        state    <= ST_GRANT;
                    end else begin
                        gntValid <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (!req[gntId]) begin
                        ptr <= nextPtr;
                        if (req != '0) begin
                            gntId   <= rrPick(req, nextPtr);
                            holdCnt <= 8'd1;
                        end else begin
                            gntValid <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end else if (atMax && otherReq) begin
                        ptr     <= nextPtr;
                        gntId   <= rrPick(req, nextPtr);
                        holdCnt <= 8'd1;
                    end else if (!atMax) begin
                        holdCnt <= holdCnt + 8'd1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    gntValid <= 1'b0;
                end
            endcase
        end
    end

    structuralDecoder u_decoder (
        .out0   (gnt[0]),
        .out1   (gnt[1]),
        .out2   (gnt[2]),
        .out3   (gnt[3]),
        .addr0  (gntId[0]),
        .addr1  (gntId[1]),
        .enable (gntValid)
    );

endmodule

// File: tb/tb_decoder_arbiter.sv
// Self-checking bench for decoder_arbiter: two instances (MAX_HOLD=2 and the
// default 8) share clock, reset and req; directed scenarios plus a random
// run compared against a rule-level reference model of each instance.
module tb_decoder_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;

    logic [3:0] gntA, gntB;
    logic [1:0] gntIdA, gntIdB;
    logic       gntValidA, gntValidB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_arbiter #(.MAX_HOLD(2)) u_a (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .gnt      (gntA),
        .gntId    (gntIdA),
        .gntValid (gntValidA)
    );

    decoder_arbiter u_b (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .gnt      (gntB),
        .gntId    (gntIdB),
        .gntValid (gntValidB)
    );

    // Reference model, index 0 = MAX_HOLD 2, index 1 = MAX_HOLD 8.
    int mOwner [2];
    int mValid [2];
    int mPtr   [2];
    int mCnt   [2];
    int mHold  [2] = '{2, 8};

    function automatic int refPick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return p;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                mOwner[m] = 0; mValid[m] = 0; mPtr[m] = 0; mCnt[m] = 0;
            end else if (mValid[m] == 0) begin
                if (req != 4'b0) begin
                    mOwner[m] = refPick(req, mPtr[m]);
                    mValid[m] = 1;
                    mCnt[m]   = 1;
                end
            end else begin
                automatic int o = mOwner[m];
                automatic logic [3:0] others = req & ~(4'b0001 << o);
                if (!req[o]) begin
                    mPtr[m] = (o + 1) % 4;
                    if (req != 4'b0) begin
                        mOwner[m] = refPick(req, mPtr[m]);
                        mCnt[m]   = 1;
                    end else begin
                        mValid[m] = 0;
                    end
                end else if (mCnt[m] == mHold[m] && others != 4'b0) begin
                    mPtr[m]   = (o + 1) % 4;
                    mOwner[m] = refPick(req, mPtr[m]);
                    mCnt[m]   = 1;
                end else if (mCnt[m] < mHold[m]) begin
                    mCnt[m] = mCnt[m] + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (gntA !== 4'b0000 || gntB !== 4'b0000 || gntValidA !== 1'b0 || gntValidB !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold cycle %0d: gntA=%b gntB=%b validA=%b validB=%b, want 0000/0000/0/0",
                         c, gntA, gntB, gntValidA, gntValidB);
            end
        end
        reset = 1'b0;
        checks++;
        if (gntA !== 4'b0000 || gntB !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_after: gntA=%b gntB=%b, want 0000", gntA, gntB);
        end
        tick();
        checks++;
        if (gntIdA !== 2'd0 || gntIdB !== 2'd0 || gntA !== 4'b0001 || gntB !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: idA=%0d idB=%0d gntA=%b gntB=%b, want 0/0/0001/0001",
                     gntIdA, gntIdB, gntA, gntB);
        end
    endtask

    task automatic test_single();
        applyReset();
        req = 4'b0100;
        tick();
        checks++;
        if (gntIdB !== 2'd2 || gntB !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL single_grant: id=%0d gnt=%b, want 2/0100", gntIdB, gntB);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gntB !== 4'b0000 || gntValidB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_release: gnt=%b valid=%b, want 0000/0", gntB, gntValidB);
        end
        req = 4'b1111;
        tick();
        checks++;
        if (gntIdB !== 2'd3) begin
            errors++;
            $display("[TB] FAIL single_ptr_after_release: id=%0d, want 3", gntIdB);
        end
    endtask

    task automatic test_round_robin();
        int expSeq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        applyReset();
        req = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (gntIdA !== 2'(expSeq[c]) || gntA === 4'b0000) begin
                errors++;
                $display("[TB] FAIL round_robin cycle %0d: id=%0d gnt=%b, want id %0d nonzero gnt",
                         c, gntIdA, gntA, expSeq[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        applyReset();
        req = 4'b0010;
        tick();
        tick();
        checks++;
        if (gntB !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL handover_owner: gnt=%b, want 0010", gntB);
        end
        req = 4'b1000;
        tick();
        checks++;
        if (gntB !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL handover_next: gnt=%b, want 1000", gntB);
        end
    endtask

    task automatic test_saturation();
        applyReset();
        req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (gntB !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL saturate_gnt cycle %0d: gnt=%b, want 0001", c, gntB);
            end
        end
        checks++;
        if (u_b.holdCnt !== 8'd8) begin
            errors++;
            $display("[TB] FAIL saturate_count: holdCnt=%0d, want 8", u_b.holdCnt);
        end
        req = 4'b0011;
        tick();
        checks++;
        if (gntB !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL saturate_preempt: gnt=%b, want 0010", gntB);
        end
    endtask

    task automatic test_mid_reset();
        applyReset();
        req = 4'b1000;
        tick();
        tick();
        checks++;
        if (gntB !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL midreset_owner: gnt=%b, want 1000", gntB);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (gntB !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midreset_clear: gnt=%b, want 0000", gntB);
        end
        reset = 1'b0;
        req   = 4'b1001;
        tick();
        checks++;
        if (gntIdB !== 2'd0 || gntB !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL midreset_ptr: id=%0d gnt=%b, want 0/0001", gntIdB, gntB);
        end
    endtask

    task automatic test_random();
        logic [3:0] expA, expB;
        applyReset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) req = 4'($urandom);
            tick();
            expA = (mValid[0] != 0) ? (4'b0001 << mOwner[0]) : 4'b0000;
            expB = (mValid[1] != 0) ? (4'b0001 << mOwner[1]) : 4'b0000;
            checks++;
            if (gntA !== expA || gntValidA !== 1'(mValid[0])) begin
                errors++;
                $display("[TB] FAIL random_hold2 cycle %0d: gnt=%b valid=%b, want %b/%0d",
                         c, gntA, gntValidA, expA, mValid[0]);
            end
            checks++;
            if (gntB !== expB || gntValidB !== 1'(mValid[1])) begin
                errors++;
                $display("[TB] FAIL random_hold8 cycle %0d: gnt=%b valid=%b, want %b/%0d",
                         c, gntB, gntValidB, expB, mValid[1]);
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
